// File: rtl/lmi_ifill_resp.sv
// rtl/lmi_ifill_resp.sv - icache line-fill responder: fetches one line from LMI and returns it word by word
// Optional build macro LMI_IFILL_ERR_EN adds mem_err_i / fill_err_o error reporting.
module lmi_ifill_resp #(
  parameter int LINE_WORDS = 4,
  parameter int WIDX_W     = 2
) (
  input  logic        clk_i,
  input  logic        reset_d1_r_i,
  input  logic        ic_miss_r_i,
  input  logic [31:0] ic_missaddr_i,
  input  logic        memsequential_i,
  input  logic        memzerofirst_i,
  input  logic        invalidate_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  output logic        mem_seq_o,
  input  logic        mem_rdy_i,
  input  logic [31:0] mem_rdata_i,
`ifdef LMI_IFILL_ERR_EN
  input  logic        mem_err_i,
  output logic        fill_err_o,
`endif
  output logic [31:0] ix_dataupi_o,
  output logic [1:0]  lack_o,
  output logic        fill_busy_o
);

  typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_GAP, ST_DONE} state_t;

  localparam logic [31:0] OFS_MASK = 32'((1 << (WIDX_W + 2)) - 1);

  state_t              state_q;
  logic [31:0]         base_q;
  logic [WIDX_W-1:0]   idx_q;
  logic [WIDX_W-1:0]   beat_q;
  logic                seq_mode_q;
  logic                mem_req_q;
  logic [31:0]         mem_addr_q;
  logic                mem_seq_q;
  logic [31:0]         ix_data_q;
  logic [1:0]          lack_q;
  logic                fill_busy_q;
`ifdef LMI_IFILL_ERR_EN
  logic                fill_err_q;
`endif

  logic [31:0]         base_d;
  logic [WIDX_W-1:0]   start_idx_d;
  logic [WIDX_W-1:0]   idx_inc_d;
  logic [31:0]         next_addr_d;
  logic [31:0]         cur_addr_d;
  logic                last_beat_d;
  logic                beat_accept_d;

  // Index arithmetic is confined to WIDX_W bits, so wrapping never disturbs the line base.
  assign base_d        = ic_missaddr_i & ~OFS_MASK;
  assign start_idx_d   = memzerofirst_i ? '0 : ic_missaddr_i[WIDX_W+1:2];
  assign idx_inc_d     = idx_q + WIDX_W'(1);
  assign next_addr_d   = base_q | 32'({idx_inc_d, 2'b00});
  assign cur_addr_d    = base_q | 32'({idx_q, 2'b00});
  assign last_beat_d   = (beat_q == WIDX_W'(LINE_WORDS - 1));
  assign beat_accept_d = mem_req_q & mem_rdy_i;

  always_ff @(posedge clk_i or posedge reset_d1_r_i) begin
    if (reset_d1_r_i) begin
      state_q     <= ST_IDLE;
      base_q      <= '0;
      idx_q       <= '0;
      beat_q      <= '0;
      seq_mode_q  <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_addr_q  <= '0;
      mem_seq_q   <= 1'b0;
      ix_data_q   <= '0;
      lack_q      <= 2'b00;
      fill_busy_q <= 1'b0;
`ifdef LMI_IFILL_ERR_EN
      fill_err_q  <= 1'b0;
`endif
    end else begin
      lack_q <= 2'b00;
`ifdef LMI_IFILL_ERR_EN
      fill_err_q <= 1'b0;
`endif
      case (state_q)
        ST_IDLE: begin
          if (ic_miss_r_i) begin
            base_q      <= base_d;
            idx_q       <= start_idx_d;
            beat_q      <= '0;
            seq_mode_q  <= memsequential_i;
            mem_req_q   <= 1'b1;
            mem_seq_q   <= 1'b0;
            mem_addr_q  <= base_d | 32'({start_idx_d, 2'b00});
            fill_busy_q <= 1'b1;
            state_q     <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (invalidate_i) begin
            state_q     <= ST_IDLE;
            mem_req_q   <= 1'b0;
            mem_seq_q   <= 1'b0;
            fill_busy_q <= 1'b0;
          end else if (beat_accept_d) begin
            ix_data_q <= mem_rdata_i;
            lack_q    <= {last_beat_d, 1'b1};
            idx_q     <= idx_inc_d;
            beat_q    <= beat_q + WIDX_W'(1);
            if (last_beat_d) begin
              state_q   <= ST_DONE;
              mem_req_q <= 1'b0;
              mem_seq_q <= 1'b0;
            end else if (seq_mode_q) begin
              mem_addr_q <= next_addr_d;
              mem_seq_q  <= 1'b1;
            end else begin
              state_q   <= ST_GAP;
              mem_req_q <= 1'b0;
              mem_seq_q <= 1'b0;
            end
`ifdef LMI_IFILL_ERR_EN
            // An errored beat terminates the line early; later assignments win.
            if (mem_err_i) begin
              ix_data_q   <= '0;
              lack_q      <= 2'b11;
              fill_err_q  <= 1'b1;
              state_q     <= ST_IDLE;
              mem_req_q   <= 1'b0;
              mem_seq_q   <= 1'b0;
              fill_busy_q <= 1'b0;
            end
`endif
          end
        end
        ST_GAP: begin
          if (invalidate_i) begin
            state_q     <= ST_IDLE;
            fill_busy_q <= 1'b0;
          end else begin
            state_q    <= ST_REQ;
            mem_req_q  <= 1'b1;
            mem_seq_q  <= 1'b0;
            mem_addr_q <= cur_addr_d;
          end
        end
        default: begin
          state_q     <= ST_IDLE;
          mem_req_q   <= 1'b0;
          mem_seq_q   <= 1'b0;
          fill_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign mem_req_o    = mem_req_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_seq_o    = mem_seq_q;
  assign ix_dataupi_o = ix_data_q;
  assign lack_o       = lack_q;
  assign fill_busy_o  = fill_busy_q;
`ifdef LMI_IFILL_ERR_EN
  assign fill_err_o   = fill_err_q;
`endif

endmodule

// File: tb/tb_lmi_ifill_resp.sv
// tb/tb_lmi_ifill_resp.sv - randomized line-fill bench with a transaction-level reference model
module tb_lmi_ifill_resp;

  localparam int LW = 4;

  logic        clk;
  logic        rst;
  logic        ic_miss;
  logic [31:0] ic_addr;
  logic        mseq;
  logic        mzf;
  logic        inval;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_seq;
  logic        mem_rdy;
  logic [31:0] mem_rdata;
  logic [31:0] ix_data;
  logic [1:0]  lack;
  logic        busy;
`ifdef LMI_IFILL_ERR_EN
  logic        fill_err;
`endif

  lmi_ifill_resp #(.LINE_WORDS(LW), .WIDX_W(2)) dut (
    .clk_i(clk), .reset_d1_r_i(rst), .ic_miss_r_i(ic_miss), .ic_missaddr_i(ic_addr),
    .memsequential_i(mseq), .memzerofirst_i(mzf), .invalidate_i(inval),
    .mem_req_o(mem_req), .mem_addr_o(mem_addr), .mem_seq_o(mem_seq),
    .mem_rdy_i(mem_rdy), .mem_rdata_i(mem_rdata),
`ifdef LMI_IFILL_ERR_EN
    .mem_err_i(1'b0), .fill_err_o(fill_err),
`endif
    .ix_dataupi_o(ix_data), .lack_o(lack), .fill_busy_o(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Fill context of the reference model
  bit          f_active, f_gap, f_done, f_seqm;
  int          f_beats, f_start;
  logic [31:0] f_base;
  logic [1:0]  m_lack;
  logic [31:0] m_data;

  // Stimulus controls
  bit          want_miss;
  logic [31:0] cur_addr;
  bit          cur_seq, cur_zf;
  bit          rdy_rand, inv_rand;
  int          rdy_q[$];
  int          inv_q[$];
  logic [31:0] log_addr[$];
  logic        log_seq[$];
  logic [1:0]  log_lack[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    bit req_exp;
    req_exp = f_active && !f_gap && !f_done && (f_beats < LW);
    chk("fill_busy", busy, f_active);
    chk("mem_req", mem_req, req_exp);
    if (req_exp) begin
      chk("mem_addr", mem_addr, f_base + ((f_start + f_beats) % LW) * 4);
      chk("mem_seq", mem_seq, f_seqm && (f_beats > 0));
    end
    chk("lack", lack, m_lack);
    if (m_lack[0]) chk("ix_data", ix_data, m_data);
  endtask

  task automatic step();
    bit          rdy, inv;
    logic [31:0] rd;
    @(negedge clk);
    check_model();
    if (lack[1]) want_miss = 1'b0;
    if (inv_rand && f_active) begin
      cur_addr = $urandom;
      cur_seq  = $urandom_range(1);
      cur_zf   = $urandom_range(1);
    end
    if (rdy_q.size() > 0) rdy = (rdy_q.pop_front() != 0);
    else rdy = rdy_rand ? ($urandom_range(9) < 7) : 1'b1;
    if (inv_q.size() > 0) inv = (inv_q.pop_front() != 0);
    else inv = inv_rand ? ($urandom_range(99) < 4) : 1'b0;
    rd = $urandom;
    ic_miss = want_miss; ic_addr = cur_addr; mseq = cur_seq; mzf = cur_zf;
    inval = inv; mem_rdy = rdy; mem_rdata = rd;
    if (mem_req && rdy && !inv) begin
      log_addr.push_back(mem_addr);
      log_seq.push_back(mem_seq);
    end
    if (lack != 2'b00) log_lack.push_back(lack);
    // Reference model: what the coming edge does to the fill
    m_lack = 2'b00;
    if (!f_active) begin
      if (want_miss) begin
        f_active = 1; f_gap = 0; f_done = 0; f_beats = 0;
        f_base   = cur_addr - (cur_addr % (LW * 4));
        f_start  = cur_zf ? 0 : int'((cur_addr % (LW * 4)) / 4);
        f_seqm   = cur_seq;
      end
    end else if (inv || f_done) begin
      f_active = 0;
    end else if (f_gap) begin
      f_gap = 0;
    end else if (rdy) begin
      m_lack = (f_beats == LW - 1) ? 2'b11 : 2'b01;
      m_data = rd;
      f_beats++;
      if (f_beats == LW) f_done = 1;
      else if (!f_seqm) f_gap = 1;
    end
  endtask

  task automatic run_fill(input logic [31:0] a, input bit sq, input bit zf);
    int budget;
    cur_addr = a; cur_seq = sq; cur_zf = zf;
    want_miss = 1'b1;
    budget = 0;
    while (want_miss && budget < 300) begin
      step();
      budget++;
    end
    if (want_miss) begin
      n_cmp++; n_bad++;
      $display("FAIL fill_timeout: no LACK[1] after %0d cycles, expected completion", budget);
      want_miss = 1'b0;
    end
    step();
  endtask

  task automatic clear_logs();
    log_addr.delete(); log_seq.delete(); log_lack.delete();
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_mem_req"}, mem_req, 0);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_seq"}, mem_seq, 0);
    chk({tag, "_lack"}, lack, 0);
    chk({tag, "_ix_data"}, ix_data, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic model_reset();
    f_active = 0; f_gap = 0; f_done = 0; f_beats = 0; m_lack = 2'b00;
    want_miss = 0;
  endtask

  initial begin
    logic [31:0] exp_a [4];
    logic [1:0]  exp_l [4];
    rst = 1'b1; ic_miss = 0; ic_addr = 0; mseq = 0; mzf = 0; inval = 0;
    mem_rdy = 0; mem_rdata = 0;
    rdy_rand = 0; inv_rand = 0; cur_addr = 0; cur_seq = 0; cur_zf = 0;
    model_reset();
    #12;
    check_zero_outputs("reset");
    @(negedge clk);
    rst = 1'b0;

    // Zero-first sequential burst
    clear_logs();
    run_fill(32'h1008, 1'b1, 1'b1);
    exp_a = '{32'h1000, 32'h1004, 32'h1008, 32'h100C};
    exp_l = '{2'b01, 2'b01, 2'b01, 2'b11};
    chk("t1_beats", log_addr.size(), 4);
    for (int i = 0; i < 4; i++) begin
      chk("t1_addr", log_addr[i], exp_a[i]);
      chk("t1_seq", log_seq[i], (i > 0) ? 1 : 0);
      chk("t1_lack", log_lack[i], exp_l[i]);
    end

    // Critical word first with wrap
    clear_logs();
    run_fill(32'h2008, 1'b1, 1'b0);
    exp_a = '{32'h2008, 32'h200C, 32'h2000, 32'h2004};
    for (int i = 0; i < 4; i++) chk("t2_addr", log_addr[i], exp_a[i]);
    chk("t2_lack_last", log_lack.size() == 4 ? log_lack[3] : 2'b00, 2'b11);

    // Non-sequential accesses
    clear_logs();
    run_fill(32'h3004, 1'b0, 1'b1);
    chk("t3_pulses", log_lack.size(), 4);
    for (int i = 0; i < 4; i++) chk("t3_seq", log_seq[i], 0);

    // Stall on beat 2
    clear_logs();
    rdy_q = '{1, 1, 0, 0, 0};
    run_fill(32'h4000, 1'b1, 1'b1);
    chk("t4_beats", log_addr.size(), 4);
    chk("t4_addr1", log_addr[1], 32'h4004);

    // Invalidate coincident with beat 3, then the held miss restarts the fill
    clear_logs();
    inv_q = '{0, 0, 0, 1};
    run_fill(32'h5000, 1'b1, 1'b1);
    chk("t5_lacks", log_lack.size(), 6);
    chk("t5_last", log_lack.size() == 6 ? log_lack[5] : 2'b00, 2'b11);

    // Asynchronous reset mid-fill
    cur_addr = 32'h6000; cur_seq = 1; cur_zf = 1; want_miss = 1;
    for (int i = 0; i < 3; i++) step();
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_zero_outputs("midreset");
    @(negedge clk);
    model_reset();
    ic_miss = 0; inval = 0; mem_rdy = 0;
    rst = 1'b0;
    clear_logs();
    run_fill(32'h6010, 1'b0, 1'b0);
    chk("t6_lacks", log_lack.size(), 4);

    // Randomized fills, abort and latching behaviour
    rdy_rand = 1; inv_rand = 1;
    for (int n = 0; n < 40; n++) begin
      run_fill($urandom, 1'($urandom_range(1)), 1'($urandom_range(1)));
      for (int k = 0; k < int'($urandom_range(2)); k++) step();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
